// File: rtl/l2_mem_responder_if.sv
// Request and response bundles for the L2 memory port.
// The L2 side drives requests and write data (master); the memory responder
// answers with read data and write completions (slave).

interface l2_mem_req_if #(
    parameter int ID_W = 4
);
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic [3:0]      arlen;

    logic            awvalid;
    logic            awready;
    logic [31:0]     awaddr;
    logic [ID_W-1:0] awid;
    logic [3:0]      awlen;

    logic            wvalid;
    logic            wready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;

    modport master (
        output arvalid, araddr, arid, arlen,
        input  arready,
        output awvalid, awaddr, awid, awlen,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen,
        output arready,
        input  awvalid, awaddr, awid, awlen,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready
    );
endinterface

interface l2_mem_resp_if #(
    parameter int ID_W = 4
);
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [ID_W-1:0] rid;
    logic            rlast;
    logic [1:0]      rresp;

    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;

    modport master (
        input  rvalid, rdata, rid, rlast, rresp,
        output rready,
        input  bvalid, bid, bresp,
        output bready
    );

    modport slave (
        output rvalid, rdata, rid, rlast, rresp,
        input  rready,
        output bvalid, bid, bresp,
        input  bready
    );
endinterface

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L2 refill/writeback bus.
// A flop-array word memory serves one read burst and one write burst at a
// time, with independent read and write state machines. Reads wait a fixed
// number of idle cycles before the first beat; bursts increment by one word
// and wrap around the array. Addresses above the array size alias.

module l2_mem_responder #(
    parameter int DEPTH_W = 10,
    parameter int ID_W    = 4,
    parameter int LAT     = 2
) (
    input  logic         clk,
    input  logic         rst,
    l2_mem_req_if.slave  l2_req_if,
    l2_mem_resp_if.slave l2_resp_if
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam logic [15:0] WAIT_INIT = (LAT > 0) ? 16'(LAT - 1) : 16'd0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    r_state_t           r_state;
    logic [DEPTH_W-1:0] r_addr;
    logic [3:0]         r_len;
    logic [3:0]         r_beat;
    logic [15:0]        r_wait;
    logic               ar_ready;
    logic               r_valid;
    logic               r_last;
    logic [31:0]        r_data;
    logic [ID_W-1:0]    r_id;

    w_state_t           w_state;
    logic [DEPTH_W-1:0] w_addr;
    logic [3:0]         w_len;
    logic [3:0]         w_beat;
    logic               aw_ready;
    logic               w_ready;
    logic               b_valid;
    logic [ID_W-1:0]    b_id;
    logic [1:0]         b_resp;

    logic               ar_fire;
    logic               r_fire;
    logic               aw_fire;
    logic               w_fire;
    logic               b_fire;
    logic               mem_we;
    logic               w_count_done;
    logic [DEPTH_W-1:0] ar_idx;
    logic [DEPTH_W-1:0] aw_idx;
    logic [DEPTH_W-1:0] r_addr_nxt;
    logic               unused_addr_bits;

    assign ar_fire      = l2_req_if.arvalid && ar_ready;
    assign r_fire       = r_valid && l2_resp_if.rready;
    assign aw_fire      = l2_req_if.awvalid && aw_ready;
    assign w_fire       = l2_req_if.wvalid && w_ready;
    assign b_fire       = b_valid && l2_resp_if.bready;
    assign mem_we       = w_fire && !rst;
    assign w_count_done = (w_beat == w_len);

    assign ar_idx     = l2_req_if.araddr[DEPTH_W+1:2];
    assign aw_idx     = l2_req_if.awaddr[DEPTH_W+1:2];
    assign r_addr_nxt = r_addr + DEPTH_W'(1);

    // Byte offset and aliased upper address bits carry no meaning here.
    assign unused_addr_bits = ^{l2_req_if.araddr[31:DEPTH_W+2], l2_req_if.araddr[1:0],
                                l2_req_if.awaddr[31:DEPTH_W+2], l2_req_if.awaddr[1:0]};

    assign l2_req_if.arready = ar_ready;
    assign l2_req_if.awready = aw_ready;
    assign l2_req_if.wready  = w_ready;

    assign l2_resp_if.rvalid = r_valid;
    assign l2_resp_if.rdata  = r_data;
    assign l2_resp_if.rid    = r_id;
    assign l2_resp_if.rlast  = r_last;
    assign l2_resp_if.rresp  = RESP_OKAY;
    assign l2_resp_if.bvalid = b_valid;
    assign l2_resp_if.bid    = b_id;
    assign l2_resp_if.bresp  = b_resp;

    // Memory array: byte-enabled writes, contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (l2_req_if.wstrb[b]) begin
                    mem[w_addr][8*b +: 8] <= l2_req_if.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read channel: accept a burst, wait out the latency, then stream beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_wait   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ar_ready <= 1'b1;
                    if (ar_fire) begin
                        ar_ready <= 1'b0;
                        r_addr   <= ar_idx;
                        r_id     <= l2_req_if.arid;
                        r_len    <= l2_req_if.arlen;
                        r_beat   <= '0;
                        r_wait   <= WAIT_INIT;
                        if (LAT == 0) begin
                            r_state <= R_DATA;
                            r_valid <= 1'b1;
                            r_data  <= mem[ar_idx];
                            r_last  <= (l2_req_if.arlen == 4'd0);
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_wait == 16'd0) begin
                        r_state <= R_DATA;
                        r_valid <= 1'b1;
                        r_data  <= mem[r_addr];
                        r_last  <= (r_len == 4'd0);
                    end else begin
                        r_wait <= r_wait - 16'd1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (r_last) begin
                            r_state  <= R_IDLE;
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            ar_ready <= 1'b1;
                        end else begin
                            r_addr <= r_addr_nxt;
                            r_data <= mem[r_addr_nxt];
                            r_beat <= r_beat + 4'd1;
                            r_last <= ((r_beat + 4'd1) == r_len);
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // Write channel: accept a burst, absorb data beats, then report completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_id     <= '0;
            b_resp   <= RESP_OKAY;
            w_addr   <= '0;
            w_len    <= '0;
            w_beat   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_ready <= 1'b1;
                    if (aw_fire) begin
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        w_addr   <= aw_idx;
                        w_len    <= l2_req_if.awlen;
                        w_beat   <= '0;
                        b_id     <= l2_req_if.awid;
                        w_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= w_addr + DEPTH_W'(1);
                        w_beat <= w_beat + 4'd1;
                        if (l2_req_if.wlast || w_count_done) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_resp  <= (l2_req_if.wlast && w_count_done) ? RESP_OKAY : RESP_SLVERR;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire) begin
                        b_valid  <= 1'b0;
                        aw_ready <= 1'b1;
                        w_state  <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Self-checking bench for l2_mem_responder.
// A word-array model tracks memory contents from the write rules; reads are
// compared beat by beat against it, alongside a table of directed vectors
// with fixed expected values and a few hand-timed corner sequences.

module tb_l2_mem_responder;

    localparam int DEPTH_W = 10;
    localparam int ID_W    = 4;
    localparam int LAT     = 2;
    localparam int DEPTH   = 1 << DEPTH_W;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst;

    int checks;
    int errors;

    logic [31:0] model [DEPTH];
    logic [31:0] wbuf  [16];
    logic [3:0]  sbuf  [16];
    logic [31:0] rbuf  [16];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [8];

    l2_mem_req_if  #(.ID_W(ID_W)) req_if ();
    l2_mem_resp_if #(.ID_W(ID_W)) resp_if ();

    l2_mem_responder #(
        .DEPTH_W (DEPTH_W),
        .ID_W    (ID_W),
        .LAT     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .l2_req_if  (req_if),
        .l2_resp_if (resp_if)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic modelWrite(input int idx, input logic [31:0] data, input logic [3:0] strb);
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
        end
    endtask

    task automatic writeBurst(input logic [31:0] addr, input int len, input int wlastIdx,
                              input logic [ID_W-1:0] id, output logic [1:0] bresp);
        int accepted;
        int cnt;
        int idx;
        logic [1:0] expResp;
        accepted = (wlastIdx >= 0 && wlastIdx < len) ? wlastIdx + 1 : len + 1;
        expResp  = (wlastIdx == len) ? 2'b00 : 2'b10;
        @(negedge clk);
        req_if.awvalid = 1'b1;
        req_if.awaddr  = addr;
        req_if.awid    = id;
        req_if.awlen   = 4'(len);
        checkOutput("wready before aw", {31'd0, req_if.wready}, 32'd0);
        cnt = 0;
        while (req_if.awready !== 1'b1 && cnt < TIMEOUT) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("aw accept in time", {31'd0, (cnt < TIMEOUT)}, 32'd1);
        @(negedge clk);
        req_if.awvalid = 1'b0;
        checkOutput("wready after aw", {31'd0, req_if.wready}, 32'd1);
        for (int b = 0; b < accepted; b++) begin
            req_if.wvalid = 1'b1;
            req_if.wdata  = wbuf[b];
            req_if.wstrb  = sbuf[b];
            req_if.wlast  = (b == wlastIdx);
            cnt = 0;
            while (req_if.wready !== 1'b1 && cnt < TIMEOUT) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= TIMEOUT) begin
                checkOutput("w beat accept", 32'd0, 32'd1);
                break;
            end
            idx = (int'(addr[DEPTH_W+1:2]) + b) % DEPTH;
            modelWrite(idx, wbuf[b], sbuf[b]);
            @(negedge clk);
        end
        req_if.wvalid = 1'b0;
        req_if.wlast  = 1'b0;
        bresp = resp_if.bresp;
        checkOutput("bvalid after last w", {31'd0, resp_if.bvalid}, 32'd1);
        checkOutput("wready after last w", {31'd0, req_if.wready}, 32'd0);
        checkOutput("bid", 32'(resp_if.bid), 32'(id));
        checkOutput("bresp", {30'd0, bresp}, {30'd0, expResp});
        @(negedge clk);
        checkOutput("bvalid held", {31'd0, resp_if.bvalid}, 32'd1);
        resp_if.bready = 1'b1;
        @(negedge clk);
        resp_if.bready = 1'b0;
        checkOutput("bvalid after b", {31'd0, resp_if.bvalid}, 32'd0);
        checkOutput("awready after b", {31'd0, req_if.awready}, 32'd1);
    endtask

    task automatic readBurst(input logic [31:0] addr, input int len, input logic [ID_W-1:0] id,
                             input bit toggle);
        int cnt;
        int beat;
        int k;
        int idx;
        @(negedge clk);
        req_if.arvalid = 1'b1;
        req_if.araddr  = addr;
        req_if.arid    = id;
        req_if.arlen   = 4'(len);
        resp_if.rready = 1'b0;
        cnt = 0;
        while (req_if.arready !== 1'b1 && cnt < TIMEOUT) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("ar accept in time", {31'd0, (cnt < TIMEOUT)}, 32'd1);
        @(negedge clk);
        req_if.arvalid = 1'b0;
        cnt = 1;
        while (resp_if.rvalid !== 1'b1 && cnt < TIMEOUT) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("first r latency", 32'(cnt), 32'(LAT + 1));
        beat = 0;
        k = 0;
        while (beat <= len && k < TIMEOUT) begin
            if (resp_if.rvalid !== 1'b1) begin
                checkOutput("rvalid during burst", {31'd0, resp_if.rvalid}, 32'd1);
                break;
            end
            idx = (int'(addr[DEPTH_W+1:2]) + beat) % DEPTH;
            checkOutput("rdata", resp_if.rdata, model[idx]);
            checkOutput("rid", 32'(resp_if.rid), 32'(id));
            checkOutput("rlast", {31'd0, resp_if.rlast}, {31'd0, (beat == len)});
            checkOutput("rresp", {30'd0, resp_if.rresp}, 32'd0);
            rbuf[beat] = resp_if.rdata;
            resp_if.rready = !toggle || (k % 2 == 0);
            @(negedge clk);
            if (resp_if.rready) beat++;
            k++;
        end
        resp_if.rready = 1'b0;
        checkOutput("rvalid after rlast", {31'd0, resp_if.rvalid}, 32'd0);
        checkOutput("arready after rlast", {31'd0, req_if.arready}, 32'd1);
    endtask

    task automatic applyStimulus(input int i);
        logic [1:0] br;
        wbuf[0] = vecs[i].wdata;
        sbuf[0] = vecs[i].wstrb;
        writeBurst(vecs[i].waddr, 0, 0, 4'(i), br);
        readBurst(vecs[i].raddr, 0, 4'(i + 1), 1'b0);
        checkOutput($sformatf("vector %0d readback", i), rbuf[0], vecs[i].expData);
    endtask

    initial begin
        logic [1:0] br;
        logic [31:0] oldVal;
        int len;
        int wl;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF};
        vecs[2] = '{32'h0000_0020, 32'h00AA_00BB, 4'h5, 32'h0000_0020, 32'hFFAA_FFBB};
        vecs[3] = '{32'h0000_0030, 32'h0000_0000, 4'hF, 32'h0000_0030, 32'h0000_0000};
        vecs[4] = '{32'h0000_0030, 32'hAABB_CCDD, 4'hA, 32'h0000_0030, 32'hAA00_CC00};
        vecs[5] = '{32'h0000_1044, 32'h5A5A_1234, 4'hF, 32'h0000_0044, 32'h5A5A_1234};
        vecs[6] = '{32'h0000_0050, 32'h1111_1111, 4'hF, 32'h0000_0050, 32'h1111_1111};
        vecs[7] = '{32'h0000_0053, 32'h1357_9BDF, 4'hC, 32'h0000_0052, 32'h1357_1111};

        rst = 1'b1;
        req_if.arvalid = 1'b1;
        req_if.araddr  = '0;
        req_if.arid    = '0;
        req_if.arlen   = '0;
        req_if.awvalid = 1'b1;
        req_if.awaddr  = '0;
        req_if.awid    = '0;
        req_if.awlen   = '0;
        req_if.wvalid  = 1'b0;
        req_if.wdata   = '0;
        req_if.wstrb   = '0;
        req_if.wlast   = 1'b0;
        resp_if.rready = 1'b0;
        resp_if.bready = 1'b0;

        // Reset held for three cycles with requests pending.
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset arready", {31'd0, req_if.arready}, 32'd0);
            checkOutput("reset awready", {31'd0, req_if.awready}, 32'd0);
            checkOutput("reset wready", {31'd0, req_if.wready}, 32'd0);
            checkOutput("reset rvalid", {31'd0, resp_if.rvalid}, 32'd0);
            checkOutput("reset bvalid", {31'd0, resp_if.bvalid}, 32'd0);
            checkOutput("reset rlast", {31'd0, resp_if.rlast}, 32'd0);
            checkOutput("reset rdata", resp_if.rdata, 32'd0);
            checkOutput("reset rid", 32'(resp_if.rid), 32'd0);
            checkOutput("reset bid", 32'(resp_if.bid), 32'd0);
            checkOutput("reset bresp", {30'd0, resp_if.bresp}, 32'd0);
        end
        rst = 1'b0;
        req_if.arvalid = 1'b0;
        req_if.awvalid = 1'b0;
        @(negedge clk);
        checkOutput("arready after reset", {31'd0, req_if.arready}, 32'd1);
        checkOutput("awready after reset", {31'd0, req_if.awready}, 32'd1);
        checkOutput("rvalid after reset", {31'd0, resp_if.rvalid}, 32'd0);
        checkOutput("bvalid after reset", {31'd0, resp_if.bvalid}, 32'd0);

        // Fill the whole array so every later read has a defined reference.
        for (int blk = 0; blk < DEPTH / 16; blk++) begin
            for (int b = 0; b < 16; b++) begin
                wbuf[b] = $urandom;
                sbuf[b] = 4'hF;
            end
            writeBurst(32'(blk * 64), 15, 15, 4'(blk), br);
        end

        // Directed single-beat vectors with fixed expected readback.
        for (int i = 0; i < 8; i++) applyStimulus(i);

        // Four-beat burst read back under alternating backpressure.
        for (int b = 0; b < 4; b++) begin
            wbuf[b] = 32'(b + 1);
            sbuf[b] = 4'hF;
        end
        writeBurst(32'h100, 3, 3, 4'h3, br);
        checkOutput("burst bresp", {30'd0, br}, 32'd0);
        readBurst(32'h100, 3, 4'h9, 1'b1);
        for (int b = 0; b < 4; b++) checkOutput($sformatf("burst beat %0d", b), rbuf[b], 32'(b + 1));

        // Two-beat write at the last word wraps to word 0; high address aliases.
        wbuf[0] = 32'hA1A1_A1A1;
        wbuf[1] = 32'hB2B2_B2B2;
        sbuf[0] = 4'hF;
        sbuf[1] = 4'hF;
        writeBurst(32'hFFC, 1, 1, 4'h2, br);
        readBurst(32'h0, 0, 4'h1, 1'b0);
        checkOutput("wrap word0", rbuf[0], 32'hB2B2_B2B2);
        readBurst(32'h1000, 0, 4'h2, 1'b0);
        checkOutput("alias word0", rbuf[0], 32'hB2B2_B2B2);
        readBurst(32'hFFC, 1, 4'h3, 1'b0);
        checkOutput("wrap read beat0", rbuf[0], 32'hA1A1_A1A1);
        checkOutput("wrap read beat1", rbuf[1], 32'hB2B2_B2B2);

        // Early wlast and missing wlast both complete with SLVERR.
        for (int b = 0; b < 4; b++) begin
            wbuf[b] = 32'hE000_0000 + 32'(b);
            sbuf[b] = 4'hF;
        end
        writeBurst(32'h300, 3, 1, 4'h4, br);
        checkOutput("early wlast bresp", {30'd0, br}, 32'd2);
        readBurst(32'h300, 3, 4'h4, 1'b0);
        checkOutput("early wlast beat1", rbuf[1], 32'hE000_0001);
        writeBurst(32'h340, 1, -1, 4'h5, br);
        checkOutput("missing wlast bresp", {30'd0, br}, 32'd2);

        // Read load and write of the same word on the same edge.
        oldVal = model[128];
        @(negedge clk);
        req_if.arvalid = 1'b1;
        req_if.araddr  = 32'h200;
        req_if.arid    = 4'h5;
        req_if.arlen   = 4'h0;
        checkOutput("conc arready", {31'd0, req_if.arready}, 32'd1);
        @(negedge clk);
        req_if.arvalid = 1'b0;
        req_if.awvalid = 1'b1;
        req_if.awaddr  = 32'h200;
        req_if.awid    = 4'h6;
        req_if.awlen   = 4'h0;
        checkOutput("conc awready", {31'd0, req_if.awready}, 32'd1);
        @(negedge clk);
        req_if.awvalid = 1'b0;
        req_if.wvalid  = 1'b1;
        req_if.wdata   = ~oldVal;
        req_if.wstrb   = 4'hF;
        req_if.wlast   = 1'b1;
        checkOutput("conc wready", {31'd0, req_if.wready}, 32'd1);
        @(negedge clk);
        req_if.wvalid = 1'b0;
        req_if.wlast  = 1'b0;
        checkOutput("conc rvalid", {31'd0, resp_if.rvalid}, 32'd1);
        checkOutput("conc rdata old", resp_if.rdata, oldVal);
        checkOutput("conc bvalid", {31'd0, resp_if.bvalid}, 32'd1);
        resp_if.rready = 1'b1;
        resp_if.bready = 1'b1;
        @(negedge clk);
        resp_if.rready = 1'b0;
        resp_if.bready = 1'b0;
        model[128] = ~oldVal;
        checkOutput("conc rvalid done", {31'd0, resp_if.rvalid}, 32'd0);
        checkOutput("conc bvalid done", {31'd0, resp_if.bvalid}, 32'd0);
        readBurst(32'h200, 0, 4'h7, 1'b0);
        checkOutput("conc new value", rbuf[0], ~oldVal);

        // Reset in the middle of a stalled read burst drops it.
        @(negedge clk);
        req_if.arvalid = 1'b1;
        req_if.araddr  = 32'h0;
        req_if.arlen   = 4'hF;
        @(negedge clk);
        req_if.arvalid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midburst rvalid", {31'd0, resp_if.rvalid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midburst reset rvalid", {31'd0, resp_if.rvalid}, 32'd0);
        checkOutput("midburst reset rlast", {31'd0, resp_if.rlast}, 32'd0);
        @(negedge clk);
        checkOutput("midburst arready", {31'd0, req_if.arready}, 32'd1);
        checkOutput("midburst no rvalid", {31'd0, resp_if.rvalid}, 32'd0);

        // Randomized mix of bursts checked against the word model.
        for (int it = 0; it < 60; it++) begin
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 16; b++) begin
                    wbuf[b] = $urandom;
                    sbuf[b] = 4'($urandom_range(0, 15));
                end
                case ($urandom_range(0, 3))
                    0:       wl = $urandom_range(0, 15);
                    1:       wl = -1;
                    default: wl = len;
                endcase
                writeBurst($urandom, len, wl, 4'($urandom_range(0, 15)), br);
            end else begin
                readBurst($urandom, len, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Memory-side responder for the L2 refill/writeback bus: accepts read bursts on AR, write bursts on AW/W, returns data on R and completions on B. Backed by a flop-array word memory with a programmable read latency. Sits at the far end of the L2's memory port, standing in for main memory in simulation and small-SoC builds. Read and write channels run independently, one outstanding transaction each.

## Interface
- DEPTH_W, 10, log2 of memory depth in 32-bit words (1024 words)
- ID_W, 4, transaction ID width
- LAT, 2, idle cycles between AR handshake and first R beat (0 legal)

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- l2_req_if_arvalid  in  1  read request valid
- l2_req_if_arready  out  1  read request accepted
- l2_req_if_araddr  in  32  byte address; bits [1:0] ignored
- l2_req_if_arid  in  ID_W  read ID
- l2_req_if_arlen  in  4  beats minus one
- l2_resp_if_rvalid  out  1  read data valid
- l2_resp_if_rready  in  1  read data accepted
- l2_resp_if_rdata  out  32  read data
- l2_resp_if_rid  out  ID_W  echoed arid
- l2_resp_if_rlast  out  1  final beat
- l2_resp_if_rresp  out  2  always 2'b00
- l2_req_if_awvalid / awready  in / out  1  write request handshake
- l2_req_if_awaddr  in  32  byte address; bits [1:0] ignored
- l2_req_if_awid  in  ID_W  write ID
- l2_req_if_awlen  in  4  beats minus one
- l2_req_if_wvalid / wready  in / out  1  write data handshake
- l2_req_if_wdata  in  32  write data
- l2_req_if_wstrb  in  4  byte enables
- l2_req_if_wlast  in  1  final write beat
- l2_resp_if_bvalid / bready  out / in  1  write response handshake
- l2_resp_if_bid  out  ID_W  echoed awid
- l2_resp_if_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR

## Operation
- Word index = addr[DEPTH_W+1:2]; upper bits ignored (aliasing). Bursts are INCR by one word, wrapping modulo 2^DEPTH_W.
- Read FSM: R_IDLE (arready=1) -> AR handshake latches addr/id/len, counter=LAT -> R_WAIT (skipped if LAT=0) -> R_DATA. In R_DATA rvalid=1, rdata registered from array; on handshake of non-last beat, address+1 and next word loaded same edge. rlast=1 when beat count equals arlen. Handshake on rlast -> R_IDLE.
- Write FSM: W_IDLE (awready=1) -> AW handshake latches addr/id/len -> W_DATA (wready=1); each W handshake writes bytes where wstrb set, address+1. Burst ends at beat awlen+1 or at wlast, whichever first -> W_RESP (bvalid=1) until bready -> W_IDLE.
- bresp=SLVERR if wlast arrives before beat awlen+1 or is low on beat awlen+1; otherwise OKAY. Accepted beats are written regardless.
- Simultaneous read load and write to same word at same edge: read returns pre-write data.
- No ordering between read and write channels; L2 owns hazard avoidance.
- Memory contents not reset.

## Timing
- While rst=1 and on the edge it is sampled: all valids 0, arready=0, awready=0, wready=0, rlast=0, rdata/rid/bid/bresp=0, both FSMs idle. arready/awready=1 from first cycle after rst deasserts.
- AR handshake at cycle t -> first rvalid at t+1+LAT; back-to-back beats every cycle with rready held high; rvalid/rdata/rid/rlast stable while rready=0.
- Next AR accepted earliest cycle after rlast handshake.
- AW handshake at t -> wready from t+1; last W handshake at u -> bvalid at u+1, held until bready. Next AW accepted cycle after B handshake.
- wready=0 outside W_DATA; W data offered early is not consumed.
- Reset mid-burst: transaction dropped, no R/B completion, writes already performed remain.

## Test plan
- Reset: hold rst 3 cycles with arvalid=awvalid=1 -> no handshakes, all valids 0; arready=awready=1 cycle after release.
- Single write/read: AW addr 0x10 len 0, W 0xDEADBEEF strb 0xF wlast=1 -> bresp 00; AR 0x10 len 0 -> rvalid at AR+3 (LAT=2), rdata 0xDEADBEEF, rlast=1.
- Burst + backpressure: write 4 beats 0x1..0x4 at 0x100; read len 3 with rready toggling 1,0,1,0 -> data 1,2,3,4 in order, stable while stalled, rlast on 4th only.
- Byte strobes: word 0xFFFFFFFF, then strb 0x5 data 0x00AA00BB -> readback 0xFFAAFFBB.
- Wrap and alias: 2-beat write at word 1023 -> second beat lands at word 0; read at byte addr 0x1000 (DEPTH_W=10) returns word 0.
- Protocol error and concurrency: awlen=3 with wlast on beat 2 -> B after beat 2, bresp 10; concurrent read of a word being written at same edge returns old value.
